// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches 16-bit instructions, executes ALU/jump/halt
// classes, and keeps the latched ALU flags used by conditional jumps.
module pc_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_c,
    input  logic        alu_v,
    output logic [7:0]  pc,
    output logic [15:0] ir,
    output logic        exec_en,
    output logic [3:0]  flags,
    output logic        halted
);

    localparam int unsigned PC_W   = 8;
    localparam int unsigned IR_W   = 16;
    localparam int unsigned OP_W   = 7;
    localparam int unsigned FLAG_W = 4;

    localparam logic [OP_W-1:0] OP_JMP = 7'h40;
    localparam logic [OP_W-1:0] OP_JEQ = 7'h41;
    localparam logic [OP_W-1:0] OP_JNE = 7'h42;
    localparam logic [OP_W-1:0] OP_JGT = 7'h43;
    localparam logic [OP_W-1:0] OP_JLT = 7'h44;
    localparam logic [OP_W-1:0] OP_JCS = 7'h45;
    localparam logic [OP_W-1:0] OP_HLT = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [PC_W-1:0]     pc_nxt;
    logic [IR_W-1:0]     ir_nxt;
    logic [FLAG_W-1:0]   flags_nxt;
    logic                imem_req_nxt, exec_en_nxt, halted_nxt;

    logic [OP_W-1:0]     opcode;
    logic [PC_W-1:0]     lit;
    logic                is_jump, is_hlt, taken;

    // Reserved opcodes fall through to the ALU class.
    function automatic logic op_is_alu(input logic [OP_W-1:0] op);
        return !((op >= OP_JMP) && (op <= OP_JCS)) && (op != OP_HLT);
    endfunction

    assign opcode    = ir[15:9];
    assign lit       = ir[7:0];
    assign imem_addr = pc;

    // Jump decode; conditions look only at the latched flags {Z,N,C,V}.
    always_comb begin
        is_jump = 1'b0;
        taken   = 1'b0;
        is_hlt  = (opcode == OP_HLT);
        case (opcode)
            OP_JMP: begin is_jump = 1'b1; taken = 1'b1; end
            OP_JEQ: begin is_jump = 1'b1; taken = flags[3]; end
            OP_JNE: begin is_jump = 1'b1; taken = !flags[3]; end
            OP_JGT: begin is_jump = 1'b1; taken = !flags[3] && !flags[2]; end
            OP_JLT: begin is_jump = 1'b1; taken = flags[2]; end
            OP_JCS: begin is_jump = 1'b1; taken = flags[1]; end
            default: ;
        endcase
    end

    // Next-state and next-register values.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        flags_nxt = flags;
        case (state)
            IDLE: begin
                if (run) state_nxt = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    ir_nxt    = imem_data;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (is_hlt) begin
                    state_nxt = HALT;
                end else begin
                    if (is_jump) begin
                        pc_nxt = taken ? lit : PC_W'(pc + PC_W'(1));
                    end else begin
                        flags_nxt = {alu_z, alu_n, alu_c, alu_v};
                        pc_nxt    = PC_W'(pc + PC_W'(1));
                    end
                    state_nxt = run ? FETCH : IDLE;
                end
            end
            HALT: begin
                if (!run) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs are registered from the next state so they align with it.
    always_comb begin
        imem_req_nxt = (state_nxt == FETCH);
        exec_en_nxt  = (state_nxt == EXEC) && op_is_alu(ir_nxt[15:9]);
        halted_nxt   = (state_nxt == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= '0;
            ir       <= '0;
            flags    <= '0;
            imem_req <= 1'b0;
            exec_en  <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            ir       <= ir_nxt;
            flags    <= flags_nxt;
            imem_req <= imem_req_nxt;
            exec_en  <= exec_en_nxt;
            halted   <= halted_nxt;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: an instruction memory plus an instruction-level
// reference model of pc/flags/halt behaviour.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        alu_z, alu_n, alu_c, alu_v;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic        exec_en;
    logic [3:0]  flags;
    logic        halted;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
        .pc(pc), .ir(ir), .exec_en(exec_en), .flags(flags), .halted(halted)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    logic [7:0]  model_pc;
    logic [3:0]  model_flags;
    logic [15:0] model_ir;
    logic        model_halted;
    int          vectors = 0;
    int          errors  = 0;

    function automatic bit m_is_jump(input logic [6:0] op);
        return (op >= 7'h40) && (op <= 7'h45);
    endfunction

    function automatic bit m_is_alu(input logic [6:0] op);
        return !m_is_jump(op) && (op != 7'h7F);
    endfunction

    function automatic bit m_taken(input logic [6:0] op, input logic [3:0] f);
        bit z, n, c;
        z = f[3]; n = f[2]; c = f[1];
        case (op)
            7'h40: return 1'b1;
            7'h41: return z;
            7'h42: return !z;
            7'h43: return !z && !n;
            7'h44: return n;
            7'h45: return c;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] mk(input logic [6:0] op, input logic [7:0] k);
        return {op, 1'b0, k};
    endfunction

    function automatic logic [15:0] rand_alu();
        logic [6:0] op;
        op = 7'($urandom_range(0, 127));
        while (!m_is_alu(op)) op = 7'($urandom_range(0, 127));
        return {op, 1'($urandom), 8'($urandom)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_data = 16'h0;
        {alu_z, alu_n, alu_c, alu_v} = 4'h0;
        step(); step();
        rst_n = 1'b1;
        model_pc = 8'h00; model_flags = 4'h0; model_ir = 16'h0; model_halted = 1'b0;
    endtask

    // Fetch (with wait states) and execute one instruction, then update the model.
    task automatic exec_one(input int waits, input logic [3:0] af, input bit drop_run);
        logic [15:0] instr;
        logic [6:0]  op;
        logic [7:0]  addr;
        int guard;
        imem_ack = 1'b0;
        guard = 0;
        while (imem_req !== 1'b1 && guard < 20) begin step(); guard++; end
        vectors++;
        if (imem_req !== 1'b1) begin
            errors++; $display("FAIL fetch_timeout: imem_req=%b want 1", imem_req);
            return;
        end
        vectors++;
        if (imem_addr !== model_pc) begin
            errors++; $display("FAIL fetch_addr: got %h want %h", imem_addr, model_pc);
        end
        addr  = model_pc;
        instr = mem[addr];
        op    = instr[15:9];
        for (int w = 0; w < waits; w++) begin
            imem_data = 16'($urandom);
            step();
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== addr || exec_en !== 1'b0) begin
                errors++;
                $display("FAIL wait_state: req=%b addr=%h exec_en=%b want 1 %h 0",
                         imem_req, imem_addr, exec_en, addr);
            end
        end
        imem_ack = 1'b1; imem_data = instr;
        step();
        imem_ack = 1'b0; imem_data = 16'($urandom);
        model_ir = instr;
        vectors++;
        if (exec_en !== 1'(m_is_alu(op)) || imem_req !== 1'b0 || ir !== instr) begin
            errors++;
            $display("FAIL exec_cycle: exec_en=%b req=%b ir=%h want %b 0 %h",
                     exec_en, imem_req, ir, m_is_alu(op), instr);
        end
        {alu_z, alu_n, alu_c, alu_v} = af;
        if (drop_run) run = 1'b0;
        step();
        {alu_z, alu_n, alu_c, alu_v} = ~af;
        if (op == 7'h7F) begin
            model_halted = 1'b1;
        end else if (m_is_jump(op)) begin
            model_pc = m_taken(op, model_flags) ? instr[7:0] : 8'(model_pc + 8'd1);
        end else begin
            model_flags = af;
            model_pc    = 8'(model_pc + 8'd1);
        end
        vectors++;
        if (pc !== model_pc || imem_addr !== model_pc || flags !== model_flags) begin
            errors++;
            $display("FAIL post_exec: pc=%h addr=%h flags=%h want %h %h %h",
                     pc, imem_addr, flags, model_pc, model_pc, model_flags);
        end
        vectors++;
        if (halted !== model_halted || exec_en !== 1'b0 ||
            imem_req !== 1'(!model_halted && run)) begin
            errors++;
            $display("FAIL post_state: halted=%b exec_en=%b req=%b want %b 0 %b",
                     halted, exec_en, imem_req, model_halted, !model_halted && run);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; imem_ack = 1'b1; imem_data = 16'hFFFF;
        #3;
        vectors++;
        if (pc !== 8'h00 || ir !== 16'h0 || flags !== 4'h0 ||
            imem_req !== 1'b0 || exec_en !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: pc=%h ir=%h flags=%h req=%b ex=%b h=%b want all 0",
                     pc, ir, flags, imem_req, exec_en, halted);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1; imem_data = 16'($urandom);
            step();
            vectors++;
            if (imem_req !== 1'b0 || ir !== 16'h0 || pc !== 8'h00) begin
                errors++;
                $display("FAIL idle_hold: req=%b ir=%h pc=%h want 0 0000 00", imem_req, ir, pc);
            end
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_straight_line();
        do_reset();
        for (int i = 0; i < 3; i++) mem[i] = rand_alu();
        run = 1'b1;
        for (int i = 0; i < 3; i++) exec_one(0, 4'($urandom), 1'b0);
    endtask

    task automatic test_wait_states();
        do_reset();
        mem[0] = rand_alu();
        run = 1'b1;
        exec_one(5, 4'hA, 1'b0);
    endtask

    task automatic test_cond_jump();
        do_reset();
        mem[0]     = rand_alu();
        mem[1]     = mk(7'h41, 8'h20);
        mem[8'h20] = mk(7'h42, 8'h40);
        run = 1'b1;
        exec_one(0, 4'b1000, 1'b0);
        exec_one(1, 4'b0000, 1'b0);
        vectors++;
        if (pc !== 8'h20) begin
            errors++; $display("FAIL jeq_taken: pc=%h want 20", pc);
        end
        exec_one(0, 4'b0000, 1'b0);
        vectors++;
        if (pc !== 8'h21) begin
            errors++; $display("FAIL jne_not_taken: pc=%h want 21", pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        mem[0]     = mk(7'h40, 8'hFF);
        mem[8'hFF] = rand_alu();
        run = 1'b1;
        exec_one(0, 4'h0, 1'b0);
        exec_one(0, 4'h5, 1'b0);
        vectors++;
        if (imem_addr !== 8'h00) begin
            errors++; $display("FAIL pc_wrap: addr=%h want 00", imem_addr);
        end
        exec_one(0, 4'h0, 1'b0);
        mem[8'hFF] = mk(7'h40, 8'hFF);
        exec_one(0, 4'h0, 1'b0);
        vectors++;
        if (imem_addr !== 8'hFF) begin
            errors++; $display("FAIL jmp_ff: addr=%h want ff", imem_addr);
        end
    endtask

    task automatic test_halt();
        do_reset();
        mem[0] = mk(7'h40, 8'h05);
        mem[5] = mk(7'h7F, 8'h33);
        run = 1'b1;
        exec_one(0, 4'h0, 1'b0);
        exec_one(0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1;
            step();
            vectors++;
            if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 8'h05) begin
                errors++;
                $display("FAIL halt_hold: halted=%b req=%b pc=%h want 1 0 05", halted, imem_req, pc);
            end
        end
        imem_ack = 1'b0;
        run = 1'b0;
        step();
        vectors++;
        if (halted !== 1'b0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL halt_exit: halted=%b req=%b want 0 0", halted, imem_req);
        end
        model_halted = 1'b0;
        run = 1'b1;
        step();
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h05) begin
            errors++; $display("FAIL halt_resume: req=%b addr=%h want 1 05", imem_req, imem_addr);
        end
        exec_one(0, 4'h0, 1'b0);
        vectors++;
        if (halted !== 1'b1) begin
            errors++; $display("FAIL halt_repeat: halted=%b want 1", halted);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        mem[0] = mk(7'h40, 8'h10);
        run = 1'b1;
        exec_one(0, 4'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (imem_req !== 1'b0 || pc !== 8'h00 || ir !== 16'h0) begin
            errors++;
            $display("FAIL async_rst_fetch: req=%b pc=%h ir=%h want 0 00 0000", imem_req, pc, ir);
        end
        step();
        rst_n = 1'b1;
        model_pc = 8'h00; model_flags = 4'h0; model_halted = 1'b0;
        step();
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            errors++; $display("FAIL rst_first_fetch: req=%b addr=%h want 1 00", imem_req, imem_addr);
        end
        // Abort an ALU instruction in its EXEC cycle.
        mem[0] = rand_alu();
        imem_ack = 1'b1; imem_data = mem[0];
        step();
        imem_ack = 1'b0;
        {alu_z, alu_n, alu_c, alu_v} = 4'hF;
        #2 rst_n = 1'b0;
        step();
        vectors++;
        if (flags !== 4'h0 || pc !== 8'h00 || exec_en !== 1'b0 || ir !== 16'h0) begin
            errors++;
            $display("FAIL async_rst_exec: flags=%h pc=%h ex=%b ir=%h want 0 00 0 0000",
                     flags, pc, exec_en, ir);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_random();
        bit dr;
        logic [15:0] nxt;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            case ($urandom_range(0, 19))
                0:             mem[i] = mk(7'h7F, 8'($urandom));
                1, 2, 3, 4, 5, 6, 7:
                               mem[i] = mk(7'(7'h40 + $urandom_range(0, 5)), 8'($urandom));
                default:       mem[i] = rand_alu();
            endcase
        end
        run = 1'b1;
        for (int n = 0; n < 150; n++) begin
            nxt = mem[model_pc];
            dr  = (nxt[15:9] != 7'h7F) && ($urandom_range(0, 4) == 0);
            exec_one($urandom_range(0, 3), 4'($urandom), dr);
            if (model_halted) begin
                run = 1'b0;
                step();
                vectors++;
                if (halted !== 1'b0) begin
                    errors++; $display("FAIL rand_unhalt: halted=%b want 0", halted);
                end
                model_halted = 1'b0;
                run = 1'b1;
            end else if (dr) begin
                for (int i = 0; i < 3; i++) begin
                    imem_ack = 1'b1; imem_data = 16'($urandom);
                    step();
                    vectors++;
                    if (imem_req !== 1'b0 || ir !== model_ir || pc !== model_pc) begin
                        errors++;
                        $display("FAIL rand_idle: req=%b ir=%h pc=%h want 0 %h %h",
                                 imem_req, ir, pc, model_ir, model_pc);
                    end
                end
                imem_ack = 1'b0;
                run = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_wait_states();
        test_cond_jump();
        test_wrap();
        test_halt();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have these ports; clock and reset first.
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- run  input  1  level; 1 permits instruction fetch and execution
- imem_req  output  1  instruction-fetch request to instruction memory
- imem_addr  output  8  fetch address; equals pc
- imem_ack  input  1  instruction memory has valid data this cycle
- imem_data  input  16  instruction word; opcode = [15:9], literal K = [7:0]
- alu_z, alu_n, alu_c, alu_v  input  1 each  ALU flags of the current ALU result
- pc  output  8  program counter
- ir  output  16  instruction register feeding the control unit
- exec_en  output  1  one-cycle strobe; gates the LA/LB register loads
- flags  output  4  latched {Z,N,C,V}
- halted  output  1  1 while in HALT state

Function
REQ-002 The FSM SHALL have four states: IDLE, FETCH, EXEC, HALT.
REQ-003 IDLE SHALL move to FETCH on the next edge when run=1, and stay in IDLE otherwise.
REQ-004 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc.
REQ-005 In FETCH, with imem_ack=1, ir SHALL load imem_data and the FSM SHALL go to EXEC on that edge. With imem_ack=0 the FSM SHALL stay in FETCH and hold the request; there is no timeout.
REQ-006 FETCH SHALL ignore run; a started fetch always completes.
REQ-007 imem_ack SHALL be ignored in every state except FETCH.
REQ-008 EXEC SHALL last exactly one cycle. Fetch-to-execute latency is 1 cycle after the ack edge.
REQ-009 Opcode classes, decoded from ir[15:9]:
- 7'h40 JMP: always taken
- 7'h41 JEQ: taken if flags.Z=1
- 7'h42 JNE: taken if Z=0
- 7'h43 JGT: taken if Z=0 and N=0
- 7'h44 JLT: taken if N=1
- 7'h45 JCS: taken if C=1
- 7'h7F HLT
- 7'h46-7'h7E: reserved; treated as ALU
- every other opcode: ALU
REQ-010 ALU instruction in EXEC: exec_en=1 for that cycle; flags<=\{alu_z,alu_n,alu_c,alu_v\}; pc<=pc+1 modulo 256 (8'hFF wraps to 8'h00).
REQ-011 Jump instruction in EXEC: exec_en=0; flags unchanged; pc<=K if taken, else pc+1 modulo 256.
REQ-012 Jump conditions SHALL use the latched flags, never the live alu_* inputs.
REQ-013 HLT in EXEC: exec_en=0; pc and flags unchanged; next state HALT.
REQ-014 After a non-HLT EXEC, the next state SHALL be FETCH if run=1, else IDLE.
REQ-015 HALT SHALL assert halted=1 and stay in HALT while run=1. On run=0 it SHALL go to IDLE, so restarting needs run to be deasserted and then reasserted.
REQ-016 exec_en and imem_req SHALL be Moore outputs; they SHALL never be 1 in the same cycle.
REQ-017 pc and ir SHALL change only on the edges defined in REQ-005 and REQ-010 to REQ-013.

Reset
REQ-018 rst_n=0 SHALL immediately, without waiting for clk, force:
- state=IDLE
- pc=8'h00, ir=16'h0000, flags=4'h0
- imem_req=0, exec_en=0, halted=0
REQ-019 Reset asserted mid-FETCH or mid-EXEC SHALL abort the instruction: no ir load, no flag update, no pc change is retained.
REQ-020 After rst_n rises, the first fetch SHALL be from address 8'h00 on the first edge with run=1.

Verification
REQ-021 Straight-line code. Stimulus: run=1, ack one cycle after each request, three ALU instructions at addresses 0-2. Response: imem_addr 0,1,2; exec_en pulses once per instruction, one cycle after each ack edge.
REQ-022 Wait states. Stimulus: hold imem_ack=0 for 5 cycles in FETCH. Response: imem_req stays 1, imem_addr unchanged, exec_en stays 0; EXEC follows the ack.
REQ-023 Conditional jump on latched flags. Stimulus: ALU instruction with alu_z=1, then JEQ K=8'h20 while alu_z is driven 0. Response: pc=8'h20. Repeat with JNE: pc=previous pc+1.
REQ-024 PC wrap. Stimulus: ALU instruction at 8'hFF. Response: next imem_addr=8'h00. Stimulus: JMP K=8'hFF. Response: next imem_addr=8'hFF.
REQ-025 Halt. Stimulus: HLT at 8'h05 with run=1. Response: halted=1, imem_req=0, pc=8'h05 held. Stimulus: run=0 then run=1. Response: fetch resumes at 8'h05, so HLT repeats.
REQ-026 Asynchronous reset. Stimulus: rst_n=0 between clk edges while in FETCH at pc=8'h10. Response: imem_req=0 and pc=8'h00 before the next edge; the first fetch after release is from 8'h00.
